suma: RTL and testbench

- Two-operand WIDTH-bit adder stage in the "operaciones" arithmetic datapath.
- Captures operand A and operand B through independent valid/ready handshakes.
- Releases their sum only once the upstream division stage signals completion on divisionLista.
- Result is presented with a one-cycle validoS strobe plus a carry flag.

---
 rtl/suma.sv | 94 +++++++++
 tb/tb_suma.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/suma.sv
// Two-operand WIDTH-bit adder stage: captures A and B through independent
// valid/ready handshakes and releases {carry,sum} once the division stage is done.
//
// state    | meaning
// VACIO    | no operand held, both inputs ready
// PARCIAL  | exactly one operand held
// COMPLETO | both operands held, waiting for divisionLista
module suma #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] operandoA,
    input  logic             validoA,
    output logic             listoA,
    input  logic [WIDTH-1:0] operandoB,
    input  logic             validoB,
    output logic             listoB,
    input  logic             divisionLista,
    output logic [WIDTH-1:0] salida,
    output logic             acarreo,
    output logic             validoS
);

    localparam logic [1:0] VACIO    = 2'd0;
    localparam logic [1:0] PARCIAL  = 2'd1;
    localparam logic [1:0] COMPLETO = 2'd2;

    logic [WIDTH-1:0] regA;
    logic [WIDTH-1:0] regB;
    logic             cargadoA;
    logic             cargadoB;
    logic [1:0]       estado;
    logic             capturaA;
    logic             capturaB;
    logic             liberar;
    logic [WIDTH:0]   sumaExt;

    // The two load flags are the real state; estado is only their decoded view.
    always_comb begin
        estado = VACIO;
        case ({cargadoA, cargadoB})
            2'b00:   estado = VACIO;
            2'b11:   estado = COMPLETO;
            default: estado = PARCIAL;
        endcase
    end

    assign listoA   = !cargadoA;
    assign listoB   = !cargadoB;
    assign capturaA = validoA && listoA;
    assign capturaB = validoB && listoB;
    assign liberar  = (estado == COMPLETO) && divisionLista;
    assign sumaExt  = {1'b0, regA} + {1'b0, regB};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            regA     <= '0;
            cargadoA <= 1'b0;
        end else if (liberar) begin
            cargadoA <= 1'b0;
        end else if (capturaA) begin
            regA     <= operandoA;
            cargadoA <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            regB     <= '0;
            cargadoB <= 1'b0;
        end else if (liberar) begin
            cargadoB <= 1'b0;
        end else if (capturaB) begin
            regB     <= operandoB;
            cargadoB <= 1'b1;
        end
    end

    // salida/acarreo hold between results; validoS is a single-cycle strobe.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            salida  <= '0;
            acarreo <= 1'b0;
            validoS <= 1'b0;
        end else begin
            validoS <= liberar;
            if (liberar) begin
                {acarreo, salida} <= sumaExt;
            end
        end
    end

endmodule

// File: tb/tb_suma.sv
// Directed bench for suma: inputs driven on the falling edge, outputs
// checked on the falling edge, halfway between rising edges.
module tb_suma;

    logic        clock;
    logic        reset_n;
    logic [15:0] operandoA;
    logic        validoA;
    logic        listoA;
    logic [15:0] operandoB;
    logic        validoB;
    logic        listoB;
    logic        divisionLista;
    logic [15:0] salida;
    logic        acarreo;
    logic        validoS;

    int testCount = 0;
    int failCount = 0;
    int pulseCount = 0;
    int gatedPulses;

    suma #(.WIDTH(16)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .operandoA(operandoA),
        .validoA(validoA),
        .listoA(listoA),
        .operandoB(operandoB),
        .validoB(validoB),
        .listoB(listoB),
        .divisionLista(divisionLista),
        .salida(salida),
        .acarreo(acarreo),
        .validoS(validoS)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (validoS === 1'b1) pulseCount <= pulseCount + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        operandoA = 16'h5555;
        operandoB = 16'hAAAA;
        validoA = 1'b1;
        validoB = 1'b1;
        divisionLista = 1'b1;

        // Reset held for 3 cycles with valids high
        repeat (3) @(negedge clock);
        chk("rst_salida", {16'h0, salida}, 32'h0);
        chk("rst_acarreo", {31'h0, acarreo}, 32'h0);
        chk("rst_validoS", {31'h0, validoS}, 32'h0);
        chk("rst_listoA", {31'h0, listoA}, 32'h1);
        chk("rst_listoB", {31'h0, listoB}, 32'h1);
        validoA = 1'b0;
        validoB = 1'b0;
        reset_n = 1'b1;
        @(negedge clock);
        chk("rst_nocap_listoA", {31'h0, listoA}, 32'h1);
        chk("rst_nocap_validoS", {31'h0, validoS}, 32'h0);

        // Basic sum 0x1234 + 0x0101
        operandoA = 16'h1234; operandoB = 16'h0101;
        validoA = 1'b1; validoB = 1'b1;
        @(negedge clock);
        validoA = 1'b0; validoB = 1'b0;
        chk("basic_cycle1_validoS", {31'h0, validoS}, 32'h0);
        chk("basic_cycle1_listoA", {31'h0, listoA}, 32'h0);
        @(negedge clock);
        chk("basic_validoS", {31'h0, validoS}, 32'h1);
        chk("basic_salida", {16'h0, salida}, 32'h1335);
        chk("basic_acarreo", {31'h0, acarreo}, 32'h0);
        @(negedge clock);
        chk("basic_strobe_end", {31'h0, validoS}, 32'h0);
        chk("basic_listoA_back", {31'h0, listoA}, 32'h1);
        chk("basic_salida_hold", {16'h0, salida}, 32'h1335);

        // Overflow 0xFFFF + 0x0002
        operandoA = 16'hFFFF; operandoB = 16'h0002;
        validoA = 1'b1; validoB = 1'b1;
        @(negedge clock);
        validoA = 1'b0; validoB = 1'b0;
        @(negedge clock);
        chk("ovf_validoS", {31'h0, validoS}, 32'h1);
        chk("ovf_salida", {16'h0, salida}, 32'h0001);
        chk("ovf_acarreo", {31'h0, acarreo}, 32'h1);
        @(negedge clock);

        // Gating: divisionLista low for 50 cycles, extra A ignored
        divisionLista = 1'b0;
        operandoA = 16'h0010; operandoB = 16'h0020;
        validoA = 1'b1; validoB = 1'b1;
        @(negedge clock);
        validoB = 1'b0;
        operandoA = 16'h9999;
        gatedPulses = 0;
        for (int i = 0; i < 50; i++) begin
            if (validoS !== 1'b0) gatedPulses++;
            if (i == 10) validoA = 1'b0;
            @(negedge clock);
        end
        chk("gate_no_validoS", gatedPulses, 32'h0);
        chk("gate_listoA", {31'h0, listoA}, 32'h0);
        chk("gate_listoB", {31'h0, listoB}, 32'h0);
        divisionLista = 1'b1;
        @(negedge clock);
        chk("gate_validoS", {31'h0, validoS}, 32'h1);
        chk("gate_salida", {16'h0, salida}, 32'h0030);
        chk("gate_acarreo", {31'h0, acarreo}, 32'h0);
        @(negedge clock);

        // Staggered operands
        operandoA = 16'h0003; validoA = 1'b1;
        @(negedge clock);
        validoA = 1'b0;
        chk("stag_listoA_low", {31'h0, listoA}, 32'h0);
        chk("stag_listoB_high", {31'h0, listoB}, 32'h1);
        repeat (4) @(negedge clock);
        chk("stag_wait_validoS", {31'h0, validoS}, 32'h0);
        operandoB = 16'h0004; validoB = 1'b1;
        @(negedge clock);
        validoB = 1'b0;
        chk("stag_cap_validoS", {31'h0, validoS}, 32'h0);
        @(negedge clock);
        chk("stag_validoS", {31'h0, validoS}, 32'h1);
        chk("stag_salida", {16'h0, salida}, 32'h0007);
        @(negedge clock);

        // Back-to-back pairs (1,2) then (5,5); second pair offered in the strobe cycle
        operandoA = 16'h0001; operandoB = 16'h0002;
        validoA = 1'b1; validoB = 1'b1;
        @(negedge clock);
        validoA = 1'b0; validoB = 1'b0;
        @(negedge clock);
        chk("b2b1_validoS", {31'h0, validoS}, 32'h1);
        chk("b2b1_salida", {16'h0, salida}, 32'h0003);
        chk("b2b1_listoA", {31'h0, listoA}, 32'h1);
        operandoA = 16'h0005; operandoB = 16'h0005;
        validoA = 1'b1; validoB = 1'b1;
        @(negedge clock);
        validoA = 1'b0; validoB = 1'b0;
        chk("b2b_gap_validoS", {31'h0, validoS}, 32'h0);
        @(negedge clock);
        chk("b2b2_validoS", {31'h0, validoS}, 32'h1);
        chk("b2b2_salida", {16'h000A, salida} & 32'h0000FFFF, 32'h000A);
        @(negedge clock);

        // Reset while one operand is loaded
        operandoA = 16'h0077; validoA = 1'b1;
        @(negedge clock);
        validoA = 1'b0;
        chk("mid_listoA_low", {31'h0, listoA}, 32'h0);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_listoA", {31'h0, listoA}, 32'h1);
        chk("mid_rst_salida", {16'h0, salida}, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        operandoB = 16'h0005; validoB = 1'b1;
        @(negedge clock);
        validoB = 1'b0;
        @(negedge clock);
        chk("mid_no_validoS", {31'h0, validoS}, 32'h0);
        chk("mid_listoA_high", {31'h0, listoA}, 32'h1);
        chk("mid_listoB_low", {31'h0, listoB}, 32'h0);
        operandoA = 16'h0001; validoA = 1'b1;
        @(negedge clock);
        validoA = 1'b0;
        @(negedge clock);
        chk("mid_after_validoS", {31'h0, validoS}, 32'h1);
        chk("mid_after_salida", {16'h0, salida}, 32'h0006);
        @(negedge clock);

        chk("total_pulses", pulseCount, 32'd7);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
